uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer and launcher. It sits directly upstream of the UART transmitter and accepts bytes from a host or bus write port.
- Bytes are stored in a DEPTH-entry FIFO and issued to the transmitter one at a time using its send_request / tx_busy / tx_done handshake.
- Frame timing stays in the transmitter; this block only guarantees in-order, lossless, one-frame-at-a-time launch.

Parameters:
- DATA_BITS, 8, width of one character; must match the transmitter's DATA_BITS.
- DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write strobe; one byte per cycle
- wr_data  input  DATA_BITS  byte to enqueue
- wr_ready  output  1  high when FIFO not full
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky; a write was attempted while full
- drained  output  1  FIFO empty and no frame in flight
- send_request  output  1  one-cycle launch pulse to transmitter
- tx_data  output  DATA_BITS  byte presented to transmitter; held stable between launches
- tx_busy  input  1  transmitter busy
- tx_done  input  1  transmitter one-cycle frame-complete pulse

Behaviour:
- Reset (async, active-high):
  - level=0, pointers=0, overflow=0.
  - send_request=0, tx_data=0, state=S_IDLE.
  - wr_ready=1, drained=1.
  - Reset mid-frame discards the FIFO contents and the in-flight byte. The transmitter shares the reset, so it is also returned to idle.
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits; pointers wrap naturally at DEPTH-1 -> 0.
  - Write accepted iff wr_en && level!=DEPTH, with full evaluated from the pre-edge level.
  - Write while full: data dropped, pointers unchanged, overflow set to 1 and held until reset.
  - Pop and accepted write in the same cycle: level unchanged, both pointers advance.
  - A write while full is rejected even if a pop occurs in the same cycle.
- Outputs:
  - wr_ready = (level != DEPTH), combinational from the registered level.
  - drained = (level==0) && (state==S_IDLE).
- Launch FSM, registered:
  - S_IDLE: if level!=0 && !tx_busy, then tx_data<=mem[rd_ptr], send_request<=1, pop (rd_ptr+1, level-1), go to S_WAIT_BUSY. Otherwise send_request<=0.
  - S_WAIT_BUSY: send_request<=0 unconditionally, so the pulse is exactly one cycle. When tx_busy==1, go to S_WAIT_DONE.
  - S_WAIT_DONE: on tx_done==1, go to S_IDLE. A new launch can occur on the very next edge (back-to-back frames).
  - tx_done seen in S_WAIT_BUSY (degenerate fast transmitter) is also accepted: go directly to S_IDLE.
  - tx_done or tx_busy seen in S_IDLE is ignored.
- send_request is never asserted while a launch is outstanding. This prevents the transmitter from re-latching a held request.
- Latency: with an empty FIFO and an idle transmitter, a byte written on edge N gives send_request=1 after edge N+1, and tx_data is valid in the same cycle.
- Ordering: strict FIFO; every accepted byte is launched exactly once.

Optional Feature:
- Macro: UART_TX_FIFO_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit). When flush=1 at an edge, level=0 and rd_ptr=wr_ptr=0.
  - Any write in that same cycle is discarded and is not counted as overflow.
  - A frame already launched completes normally and the FSM still waits for tx_done.
  - overflow is not cleared by flush.
- Undefined: no flush port; FIFO is cleared only by reset.

Test Plan:
1. Single byte: reset, then write 0xA5 with a real transmitter (baud_tick every cycle, parity off) -> send_request one-cycle pulse one cycle after the write with tx_data=0xA5; serial line carries 0,1,0,1,0,0,1,0,1,1; drained=1 after tx_done.
2. Burst fill: write 0x00..0x0F on 16 consecutive cycles while the transmitter is idle -> all 16 accepted; all 16 launched in order 0x00..0x0F; exactly 16 send_request pulses, none while tx_busy=1; overflow=0.
3. Overflow: hold tx_busy=1 (stub) and write 17 bytes 0x10..0x20 -> level=16, wr_ready=0, overflow=1; 0x20 lost; after releasing, launches are 0x10..0x1F.
4. Simultaneous write and pop: level=1, write 0x77 on the cycle the FSM pops -> level stays 1; 0x77 launched next.
5. Wrap-around: write and drain 40 bytes in batches of 5 (pointers wrap twice) -> output sequence matches input exactly.
6. Reset mid-frame: assert reset during the data bits of 0x3C with level=3 -> send_request=0, level=0, tx_data=0, drained=1, serial line=1 immediately; no further launches until new writes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter one frame at a time via send_request/tx_busy/tx_done.
// Optional synchronous FIFO clear via the flush port when UART_TX_FIFO_FLUSH_EN is defined.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_BITS-1:0]       wr_data,
    output logic                       wr_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       drained,
    output logic                       send_request,
    output logic [DATA_BITS-1:0]       tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done
`ifdef UART_TX_FIFO_FLUSH_EN
    ,
    input  logic                       flush
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  send_request_q, send_request_d;
    logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;
    logic [DATA_BITS-1:0]  mem_q [DEPTH];

    logic                  flush_s;
    logic                  full_s;
    logic                  wr_accept_s;
    logic                  pop_s;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign full_s      = (level_q == LW'(DEPTH));
    assign wr_accept_s = wr_en && !full_s && !flush_s;

    assign wr_ready     = !full_s;
    assign drained      = (level_q == {LW{1'b0}}) && (state_q == S_IDLE);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign send_request = send_request_q;
    assign tx_data      = tx_data_q;

    // Launch FSM: one outstanding frame; tx_done ends it whether or not busy was seen.
    always_comb begin
        state_d        = state_q;
        send_request_d = 1'b0;
        tx_data_d      = tx_data_q;
        pop_s          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((level_q != {LW{1'b0}}) && !tx_busy && !flush_s) begin
                    pop_s          = 1'b1;
                    tx_data_d      = mem_q[rd_ptr_q];
                    send_request_d = 1'b1;
                    state_d        = S_WAIT_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_done) begin
                    state_d = S_IDLE;
                end else if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer, occupancy and sticky overflow next-state.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (wr_en && full_s && !flush_s);
        if (flush_s) begin
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            level_d  = {LW{1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (wr_accept_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({wr_accept_s, pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rd_ptr_q       <= {AW{1'b0}};
            wr_ptr_q       <= {AW{1'b0}};
            level_q        <= {LW{1'b0}};
            overflow_q     <= 1'b0;
            send_request_q <= 1'b0;
            tx_data_q      <= {DATA_BITS{1'b0}};
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            level_q        <= level_d;
            overflow_q     <= overflow_d;
            send_request_q <= send_request_d;
            tx_data_q      <= tx_data_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: queue-based reference model, transmitter stub, per-cycle compare.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_busy;
    logic       tx_done;
    logic       flush = 1'b0;
    logic       wr_ready;
    logic [4:0] level;
    logic       overflow;
    logic       drained;
    logic       send_request;
    logic [7:0] tx_data;

    // Transmitter stub controls and state.
    logic       hold_busy = 1'b0;
    logic       fast_mode = 1'b0;
    int         frame_len = 4;
    int         st_cnt = 0;
    logic       st_busy = 1'b0;
    logic       st_done = 1'b0;

    // Reference model state.
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_inflight = 1'b0;
    logic       m_sr = 1'b0;
    logic [7:0] m_tx = 8'h00;

    int checks = 0;
    int failures = 0;
    int pin_id = 0;

    uart_tx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .level        (level),
        .overflow     (overflow),
        .drained      (drained),
        .send_request (send_request),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
`ifdef UART_TX_FIFO_FLUSH_EN
        ,
        .flush        (flush)
`endif
    );

    always #5 clk = ~clk;

    assign tx_busy = st_busy | hold_busy;
    assign tx_done = st_done;

    // Transmitter stub: busy for frame_len cycles then a done pulse; fast mode skips busy.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            st_cnt  <= 0;
            st_busy <= 1'b0;
            st_done <= 1'b0;
        end else begin
            st_done <= 1'b0;
            if (st_cnt != 0) begin
                st_cnt <= st_cnt - 1;
                if (st_cnt == 1) begin
                    st_busy <= 1'b0;
                    st_done <= 1'b1;
                end
            end else if (send_request) begin
                if (fast_mode) begin
                    st_done <= 1'b1;
                end else begin
                    st_busy <= 1'b1;
                    st_cnt  <= frame_len;
                end
            end
        end
    end

    // Reference model: a byte queue, a launch-outstanding flag and a sticky overflow bit.
    initial forever begin
        int  pre;
        logic pop;
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            m_ovf      = 1'b0;
            m_inflight = 1'b0;
            m_sr       = 1'b0;
            m_tx       = 8'h00;
        end else begin
            pre  = mq.size();
            pop  = !m_inflight && (pre != 0) && !tx_busy;
            m_sr = pop;
            if (m_inflight) begin
                if (tx_done) m_inflight = 1'b0;
            end else if (pop) begin
                m_tx       = mq.pop_front();
                m_inflight = 1'b1;
            end
            if (wr_en) begin
                if (pre == DEPTH) m_ovf = 1'b1;
                else mq.push_back(wr_data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus pinned literal expectations on request.
    always @(negedge clk) begin
        chk("level", 32'(level), 32'(mq.size()));
        chk("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drained", 32'(drained), 32'((mq.size() == 0) && !m_inflight));
        chk("send_request", 32'(send_request), 32'(m_sr));
        chk("tx_data", 32'(tx_data), 32'(m_tx));
        case (pin_id)
            1: begin
                chk("rst_level", 32'(level), 32'd0);
                chk("rst_wr_ready", 32'(wr_ready), 32'd1);
                chk("rst_drained", 32'(drained), 32'd1);
                chk("rst_tx_data", 32'(tx_data), 32'h00);
            end
            2: begin
                chk("lat_send_request", 32'(send_request), 32'd1);
                chk("lat_tx_data", 32'(tx_data), 32'hA5);
            end
            3: begin
                chk("full_level", 32'(level), 32'd16);
                chk("full_wr_ready", 32'(wr_ready), 32'd0);
                chk("full_overflow", 32'(overflow), 32'd1);
            end
            4: begin
                chk("midrst_level", 32'(level), 32'd0);
                chk("midrst_send_request", 32'(send_request), 32'd0);
                chk("midrst_tx_data", 32'(tx_data), 32'h00);
                chk("midrst_drained", 32'(drained), 32'd1);
                chk("midrst_overflow", 32'(overflow), 32'd0);
            end
            5: chk("drain_done", 32'(drained), 32'd1);
            6: begin
                chk("burst_drained", 32'(drained), 32'd1);
                chk("burst_overflow", 32'(overflow), 32'd0);
            end
            default: ;
        endcase
    end

    task automatic pin(input int id);
        #1 pin_id = id;
        @(negedge clk);
        #1 pin_id = 0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
    endtask

    task automatic idle_write();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (drained === 1'b1) break;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        pin(1);

        // Single byte: launch pulse one cycle after the write edge.
        frame_len = 10;
        write_byte(8'hA5);
        idle_write();
        pin(2);
        wait_drained(100);
        pin(5);

        // Burst of 16 into an idle transmitter.
        frame_len = 3;
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        idle_write();
        wait_drained(400);
        pin(6);

        // Overflow while the transmitter is held busy.
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) write_byte(8'h10 + 8'(i));
        idle_write();
        pin(3);
        hold_busy = 1'b0;
        wait_drained(400);
        pin(5);

        // Random traffic: mixed densities, frame lengths and fast transmitter frames.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            frame_len = $urandom_range(1, 6);
            fast_mode = ($urandom_range(0, 3) == 0);
            if ((i / 100) % 2 == 0) wr_en = ($urandom_range(0, 3) == 0);
            else wr_en = ($urandom_range(0, 3) != 0);
            wr_data = 8'($urandom);
        end
        idle_write();
        fast_mode = 1'b0;
        wait_drained(1000);
        pin(5);

        // Reset in the middle of a frame with bytes still queued.
        frame_len = 12;
        write_byte(8'h3C);
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        idle_write();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (tx_busy === 1'b1) break;
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        pin(4);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        pin(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
